// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_using_half_adders.sv
// One-bit full adder made of two half-adder stages plus a carry OR.
module full_adder_using_half_adders (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1  = a ^ b;
  assign hc1  = a & b;
  assign sum  = hs1 ^ cin;
  assign hc2  = hs1 & cin;
  assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry FF, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// SHIFT | adding one bit per cycle, LSB first
// DONE  | result held on sum/cout until the sink takes it
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             slice_sum;
  logic             slice_cout;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_LAST);

  full_adder_using_half_adders u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_sh;
    cout      = carry_q;
  end

  // Sum bits enter at the MSB end so that after WIDTH shifts bit 0 sits at sum_sh[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          sum_sh  <= {slice_sum, sum_sh[WIDTH-1:1]};
          carry_q <= slice_cout;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_carry_q;

  // On the last SHIFT cycle carry_q is the carry into the MSB slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               msb_carry_q <= 1'b0;
    else if (state_q == SHIFT && last_bit) msb_carry_q <= carry_q;
  end

  assign ovf = msb_carry_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Builds with or without SERIAL_ADDER_OVF_EN; ovf is checked only when present.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_chk;
  int n_pass;
  int cyc;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One complete transaction; inputs change 1 time unit after a rising edge.
  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, in_ready, 1'b0);
    wait_out_valid(lat);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unused");
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, out_valid, 1'b0);
    chk({tag, "_rdy"}, in_ready, 1'b1);
  endtask

  logic [7:0] bb_a   [3] = '{8'h5A, 8'hFF, 8'hFF};
  logic [7:0] bb_b   [3] = '{8'h3C, 8'h01, 8'hFF};
  logic       bb_c   [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] bb_sum [3] = '{8'h96, 8'h00, 8'hFF};
  logic       bb_co  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int lat;
    int acc_cyc [3];
    int guard;
    n_chk = 0; n_pass = 0; cyc = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    do_add("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_add("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure: hold the result for 5 cycles while in_valid is pulsed.
    a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'h11 + 8'(i); b = 8'h22; cin = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum", sum, 8'h96);
      chk("bp_cout", cout, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", out_valid, 1'b0);
    chk("bp_idle", in_ready, 1'b1);

    // Back-to-back: in_valid and out_ready held high across three operand pairs.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = bb_a[k]; b = bb_b[k]; cin = bb_c[k];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 30) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("b2b_ready_wait", (guard < 30), 1'b1);
      @(posedge clk);
      acc_cyc[k] = cyc;
      #1;
      a = 8'hA5; b = 8'h5A; cin = 1'b1;
      wait_out_valid(lat);
      chk("b2b_lat", lat, 8);
      chk("b2b_sum", sum, bb_sum[k]);
      chk("b2b_cout", cout, bb_co[k]);
    end
    in_valid = 1'b0;
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 10);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 10);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset asserted asynchronously after three bits of an add.
    a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 8'h00);
    chk("mid_rst_cout", cout, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    do_add("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
